// File: rtl/dot_product_pkg.sv
// Shared types and defaults for the dot-product datapath (writer, reader, mem3, top level).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dot_product_pkg;

    // Default build parameters shared across the system.
    localparam int unsigned DEF_DATA_WIDTH      = 8;
    localparam int unsigned DEF_VECTOR_WIDTH    = 4;
    localparam int unsigned DEF_ADDR_WIDTH      = 5;
    localparam int unsigned DEF_BASE_ADDR       = 0;
    localparam int unsigned DEF_MEM3_ADDR_WIDTH = 4;

    // Reader control states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Width that holds a sum of vw full-width unsigned products without overflow.
    function automatic int unsigned result_width(input int unsigned dw, input int unsigned vw);
        return 2 * dw + $clog2(vw);
    endfunction

endpackage

// File: rtl/dot_product_reader_mac_accumulator.sv
// Registered unsigned multiply-accumulate: acc <= clear ? 0 : acc + a*b when valid.
// Latency: 1 cycle from valid/a/b to updated acc.
// Backpressure: none; every valid cycle is absorbed.
//
// Ports:
//   clk, rst_n   clock and async active-low reset (acc -> 0)
//   i_clear      synchronous clear, wins over i_valid
//   i_valid      qualifies i_a/i_b for accumulation
//   i_a, i_b     DATA_WIDTH unsigned operands
//   o_acc        RESULT_WIDTH running sum
module mac_accumulator #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned RESULT_WIDTH = 18
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clear,
    input  logic                    i_valid,
    input  logic [DATA_WIDTH-1:0]   i_a,
    input  logic [DATA_WIDTH-1:0]   i_b,
    output logic [RESULT_WIDTH-1:0] o_acc
);

    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [RESULT_WIDTH-1:0] r_acc;

    // Zero-extend operands so the product is computed at full width.
    assign w_prod = {{DATA_WIDTH{1'b0}}, i_a} * {{DATA_WIDTH{1'b0}}, i_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_valid) begin
            r_acc <= r_acc + RESULT_WIDTH'(w_prod);
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/dot_product_reader.sv
// Reads VECTOR_WIDTH A/B element pairs, accumulates their dot product and writes it to mem3.
// Latency: reading_done/res_wr_en rise VECTOR_WIDTH+2 edges after start is sampled; busy for VECTOR_WIDTH+3 cycles.
// Backpressure: none; start_reading is ignored (not queued) while not IDLE.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start_reading              start request, sampled only in IDLE
//   mem_rd_en, mem_rd_addr     shared read strobe/address to A and B memories
//   mem_a_data, mem_b_data     read data, valid one cycle after mem_rd_en
//   res_wr_en/addr/data        single-cycle mem3 write of the dot product
//   busy, reading_done         activity flag and one-cycle completion pulse
//   result_count               number of results written, wrapping
module dot_product_reader
    import dot_product_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int unsigned VECTOR_WIDTH    = DEF_VECTOR_WIDTH,
    parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int unsigned BASE_ADDR       = DEF_BASE_ADDR,
    parameter int unsigned RESULT_WIDTH    = result_width(DEF_DATA_WIDTH, DEF_VECTOR_WIDTH),
    parameter int unsigned MEM3_ADDR_WIDTH = DEF_MEM3_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_reading,
    output logic                       mem_rd_en,
    output logic [ADDR_WIDTH-1:0]      mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]      mem_a_data,
    input  logic [DATA_WIDTH-1:0]      mem_b_data,
    output logic                       res_wr_en,
    output logic [MEM3_ADDR_WIDTH-1:0] res_wr_addr,
    output logic [RESULT_WIDTH-1:0]    res_wr_data,
    output logic                       busy,
    output logic                       reading_done,
    output logic [MEM3_ADDR_WIDTH-1:0] result_count
);

    localparam int unsigned CNT_WIDTH = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(VECTOR_WIDTH - 1);

    state_t                     r_state;
    logic [CNT_WIDTH-1:0]       r_rd_cnt;
    logic                       r_rd_en;
    logic [ADDR_WIDTH-1:0]      r_rd_addr;
    logic                       r_rd_vld;     // mem_rd_en delayed to line up with read data
    logic                       r_wr_en;
    logic [MEM3_ADDR_WIDTH-1:0] r_wr_addr;
    logic [RESULT_WIDTH-1:0]    r_wr_data;
    logic                       r_busy;
    logic                       r_done;
    logic [MEM3_ADDR_WIDTH-1:0] r_result_count;

    logic                       w_start;
    logic [RESULT_WIDTH-1:0]    w_acc;

    // The accumulator clears on the same edge that accepts the start.
    assign w_start = (r_state == ST_IDLE) && start_reading;

    mac_accumulator #(
        .DATA_WIDTH   (DATA_WIDTH),
        .RESULT_WIDTH (RESULT_WIDTH)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_start),
        .i_valid (r_rd_vld),
        .i_a     (mem_a_data),
        .i_b     (mem_b_data),
        .o_acc   (w_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_rd_cnt       <= '0;
            r_rd_en        <= 1'b0;
            r_rd_addr      <= '0;
            r_rd_vld       <= 1'b0;
            r_wr_en        <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_result_count <= '0;
        end else begin
            r_rd_vld <= r_rd_en;
            case (r_state)
                ST_IDLE: begin
                    if (start_reading) begin
                        r_state   <= ST_READ;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= ADDR_WIDTH'(BASE_ADDR);
                        r_rd_cnt  <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (r_rd_cnt == LAST_IDX) begin
                        r_rd_en <= 1'b0;
                        r_state <= ST_DRAIN;
                    end else begin
                        // Address wraps naturally at 2^ADDR_WIDTH.
                        r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
                        r_rd_cnt  <= r_rd_cnt + CNT_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    // Final product lands in the accumulator on this edge.
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_wr_en   <= 1'b1;
                    r_wr_data <= w_acc;
                    r_wr_addr <= r_result_count;
                    r_done    <= 1'b1;
                    r_state   <= ST_DONE;
                end
                ST_DONE: begin
                    r_wr_en        <= 1'b0;
                    r_done         <= 1'b0;
                    r_result_count <= r_result_count + MEM3_ADDR_WIDTH'(1);
                    r_busy         <= 1'b0;
                    r_state        <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_rd_en    = r_rd_en;
    assign mem_rd_addr  = r_rd_addr;
    assign res_wr_en    = r_wr_en;
    assign res_wr_addr  = r_wr_addr;
    assign res_wr_data  = r_wr_data;
    assign busy         = r_busy;
    assign reading_done = r_done;
    assign result_count = r_result_count;

endmodule
